// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/sleep/reset sequencer driving the core clock enable and reset
module core_run_ctrl #(
  parameter int RST_STRETCH = 16,
  parameter int WAKE_DELAY = 6,
  parameter int CNT_W = 8
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic       ext_rst_req,
  input  logic       wdt_rst_req,
  input  logic       sleep_req,
  input  logic       irq_pending,
  input  logic       dbg_halt_req,
  input  logic       dbg_step,
  input  logic       cause_clr,
  output logic       core_rst,
  output logic       cp2en,
  output logic       sleeping,
  output logic       halted,
  output logic [2:0] reset_cause,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RUN      = 3'd1,
    SLEEP    = 3'd2,
    WAKE     = 3'd3,
    HALT     = 3'd4,
    STEP     = 3'd5
  } state_t;
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_STRETCH - 1);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DELAY > 0 ? WAKE_DELAY - 1 : 0);
  state_t cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0] cause, set_bits;
  logic rst_req;
  always_comb begin
    rst_req = wdt_rst_req | ext_rst_req;
    set_bits = {wdt_rst_req, ext_rst_req, 1'b0};
    nxt = cur;
    cnt_nxt = ((cur == RST_HOLD) || (cur == WAKE)) && (cnt != '0) ? cnt - 1'b1 : cnt;
    if (rst_req) begin
      nxt = RST_HOLD;
      cnt_nxt = RST_LD;
    end else begin
      case (cur)
        RST_HOLD: nxt = (cnt == '0) ? RUN : RST_HOLD;
        RUN:      nxt = dbg_halt_req ? HALT : (sleep_req && !irq_pending) ? SLEEP : RUN;
        SLEEP:    if (irq_pending) begin
                    nxt = (WAKE_DELAY == 0) ? RUN : WAKE;
                    cnt_nxt = WAKE_LD;
                  end
        WAKE:     nxt = (cnt == '0) ? RUN : WAKE;
        HALT:     nxt = !dbg_halt_req ? RUN : dbg_step ? STEP : HALT;
        STEP:     nxt = dbg_halt_req ? HALT : RUN;
        default:  nxt = RST_HOLD;
      endcase
    end
  end
  always_ff @(posedge cp2) begin
    if (ireset) begin
      cur <= RST_HOLD;
      cnt <= RST_LD;
      cause <= 3'b001;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      cause <= (cause_clr ? 3'b000 : cause) | set_bits;
    end
  end
  assign core_rst = (cur == RST_HOLD);
  assign cp2en = (cur == RST_HOLD) || (cur == RUN) || (cur == STEP);
  assign sleeping = (cur == SLEEP) || (cur == WAKE);
  assign halted = (cur == HALT);
  assign reset_cause = cause;
  assign state = cur;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: table, corner-case and random checks of core_run_ctrl
module tb_core_run_ctrl;
  localparam int RS = 16;
  localparam int WD = 6;
  localparam logic [7:0] I = 8'h80, W = 8'h40, E = 8'h20, S = 8'h10;
  localparam logic [7:0] Q = 8'h08, H = 8'h04, T = 8'h02, C = 8'h01;
  typedef struct {
    int n;
    logic [7:0] in;
    logic [2:0] st;
    logic [2:0] cause;
  } vec_t;
  logic cp2 = 1'b0;
  logic ireset, ext_rst_req, wdt_rst_req, sleep_req, irq_pending, dbg_halt_req, dbg_step, cause_clr;
  logic core_rst, cp2en, sleeping, halted;
  logic [2:0] reset_cause, state;
  int checks = 0;
  int errors = 0;
  int m_st = 0;
  int m_left = 0;
  logic [2:0] m_cause = 3'b000;
  core_run_ctrl #(.RST_STRETCH(RS), .WAKE_DELAY(WD), .CNT_W(8)) dut (
    .cp2(cp2), .ireset(ireset), .ext_rst_req(ext_rst_req), .wdt_rst_req(wdt_rst_req),
    .sleep_req(sleep_req), .irq_pending(irq_pending), .dbg_halt_req(dbg_halt_req),
    .dbg_step(dbg_step), .cause_clr(cause_clr), .core_rst(core_rst), .cp2en(cp2en),
    .sleeping(sleeping), .halted(halted), .reset_cause(reset_cause), .state(state)
  );
  always #5 cp2 = ~cp2;
  task automatic drive(input logic [7:0] v);
    {ireset, wdt_rst_req, ext_rst_req, sleep_req, irq_pending, dbg_halt_req, dbg_step, cause_clr} = v;
  endtask
  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  // Reference: time spent in a timed mode is tracked as cycles remaining.
  task automatic model_step();
    if (ireset) begin
      m_st = 0;
      m_left = RS;
      m_cause = 3'b001;
    end else begin
      m_cause = (cause_clr ? 3'b000 : m_cause) | {wdt_rst_req, ext_rst_req, 1'b0};
      if (wdt_rst_req || ext_rst_req) begin
        m_st = 0;
        m_left = RS;
      end else if (m_st == 0) begin
        m_left = m_left - 1;
        if (m_left <= 0) m_st = 1;
      end else if (m_st == 1) begin
        if (dbg_halt_req) m_st = 4;
        else if (sleep_req && !irq_pending) m_st = 2;
      end else if (m_st == 2) begin
        if (irq_pending) begin
          m_st = (WD == 0) ? 1 : 3;
          m_left = WD;
        end
      end else if (m_st == 3) begin
        m_left = m_left - 1;
        if (m_left <= 0) m_st = 1;
      end else if (m_st == 4) begin
        if (!dbg_halt_req) m_st = 1;
        else if (dbg_step) m_st = 5;
      end else begin
        m_st = dbg_halt_req ? 4 : 1;
      end
    end
  endtask
  task automatic cyc();
    @(posedge cp2);
    model_step();
    #1;
    chk("state", {5'b0, state}, 8'(m_st));
    chk("core_rst", {7'b0, core_rst}, {7'b0, m_st == 0});
    chk("cp2en", {7'b0, cp2en}, {7'b0, m_st == 0 || m_st == 1 || m_st == 5});
    chk("sleeping", {7'b0, sleeping}, {7'b0, m_st == 2 || m_st == 3});
    chk("halted", {7'b0, halted}, {7'b0, m_st == 4});
    chk("reset_cause", {5'b0, reset_cause}, {5'b0, m_cause});
  endtask
  initial begin
    vec_t tbl[$];
    int pulses;
    drive(8'h00);
    tbl.push_back('{3, I, 3'd0, 3'b001});
    tbl.push_back('{15, 8'h00, 3'd0, 3'b001});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b001});
    tbl.push_back('{1, S, 3'd2, 3'b001});
    tbl.push_back('{9, 8'h00, 3'd2, 3'b001});
    tbl.push_back('{1, Q, 3'd3, 3'b001});
    tbl.push_back('{5, 8'h00, 3'd3, 3'b001});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b001});
    tbl.push_back('{1, S | Q, 3'd1, 3'b001});
    tbl.push_back('{2, 8'h00, 3'd1, 3'b001});
    tbl.push_back('{1, W | E, 3'd0, 3'b111});
    tbl.push_back('{15, 8'h00, 3'd0, 3'b111});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b111});
    tbl.push_back('{1, C, 3'd1, 3'b000});
    tbl.push_back('{1, H, 3'd4, 3'b000});
    tbl.push_back('{1, H | T, 3'd5, 3'b000});
    tbl.push_back('{1, H | T, 3'd4, 3'b000});
    tbl.push_back('{3, H, 3'd4, 3'b000});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b000});
    tbl.push_back('{1, H | S, 3'd4, 3'b000});
    tbl.push_back('{1, H | W, 3'd0, 3'b100});
    tbl.push_back('{1, C | E, 3'd0, 3'b010});
    tbl.push_back('{15, 8'h00, 3'd0, 3'b010});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b010});
    tbl.push_back('{1, S, 3'd2, 3'b010});
    tbl.push_back('{2, H, 3'd2, 3'b010});
    tbl.push_back('{1, H | Q, 3'd3, 3'b010});
    tbl.push_back('{5, H, 3'd3, 3'b010});
    tbl.push_back('{1, H, 3'd1, 3'b010});
    tbl.push_back('{1, H, 3'd4, 3'b010});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b010});
    tbl.push_back('{1, C | S, 3'd2, 3'b000});
    tbl.push_back('{1, Q, 3'd3, 3'b000});
    tbl.push_back('{2, 8'h00, 3'd3, 3'b000});
    tbl.push_back('{1, E, 3'd0, 3'b010});
    tbl.push_back('{15, 8'h00, 3'd0, 3'b010});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b010});
    tbl.push_back('{1, S, 3'd2, 3'b010});
    tbl.push_back('{1, W | Q, 3'd0, 3'b110});
    tbl.push_back('{15, 8'h00, 3'd0, 3'b110});
    tbl.push_back('{1, 8'h00, 3'd1, 3'b110});
    foreach (tbl[k]) begin
      drive(tbl[k].in);
      for (int r = 0; r < tbl[k].n; r++) begin
        cyc();
        chk($sformatf("tbl%0d_state", k), {5'b0, state}, {5'b0, tbl[k].st});
        chk($sformatf("tbl%0d_cause", k), {5'b0, reset_cause}, {5'b0, tbl[k].cause});
      end
    end
    drive(H);
    cyc();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(H | ((i % 4 == 0) ? T : 8'h00));
      cyc();
      pulses += int'(cp2en);
    end
    chk("step_pulses", 8'(pulses), 8'd3);
    drive(8'h00);
    cyc();
    chk("step_resume_cp2en", {7'b0, cp2en}, 8'd1);
    for (int i = 0; i < 3000; i++) begin
      ireset = ($urandom % 200) == 0;
      wdt_rst_req = ($urandom % 60) == 0;
      ext_rst_req = ($urandom % 60) == 0;
      sleep_req = ($urandom % 6) == 0;
      irq_pending = ($urandom % 8) == 0;
      if (($urandom % 25) == 0) dbg_halt_req = ~dbg_halt_req;
      dbg_step = ($urandom % 4) == 0;
      cause_clr = ($urandom % 20) == 0;
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
